// File: rtl/lsu_m.sv
// -----------------------------------------------------------------------------
// lsu_m -- load/store unit for the MEM stage of a 32-bit in-order pipeline.
//
// Accepts one load or store from the EX/MEM register, freezes the pipeline
// while the data-memory handshake is in flight, and returns the extended
// load result. A zero-wait access stalls for two cycles: IDLE detects the
// request and BUSY sees dmem_ready_i. The one-cycle DONE state then releases
// the pipeline so the held instruction is not issued a second time.
//
// Parameters
//   MAX_WAIT        BUSY cycles without dmem_ready_i before a timeout error
//
// Configuration macro
//   MISALIGN_TRAP_EN  when defined, misaligned h/hu/w accesses skip memory and
//                     raise err_m_o. When undefined, the offset bits that a
//                     halfword or word does not need are simply ignored.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   mem_read_m_i          load request
//   mem_write_m_i         store request (wins if both are set)
//   funct3_m_i            000 b, 001 h, 010 w, 100 bu, 101 hu (others: word)
//   addr_m_i, wdata_m_i   byte address and raw store data
//   dmem_req_o/we_o       memory request and write strobe
//   dmem_addr_o/be_o      word-aligned address and byte enables
//   dmem_wdata_o          lane-replicated store data
//   dmem_rdata_i/ready_i  read data, and completion in the same cycle
//   read_data_m_o         extended load result (holds until the next load)
//   stall_m_o             pipeline freeze
//   err_m_o               one-cycle timeout / misalignment pulse
// -----------------------------------------------------------------------------
module lsu_m #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mem_read_m_i,
   input  logic        mem_write_m_i,
   input  logic [2:0]  funct3_m_i,
   input  logic [31:0] addr_m_i,
   input  logic [31:0] wdata_m_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_wdata_o,
   input  logic [31:0] dmem_rdata_i,
   input  logic        dmem_ready_i,
   output logic [31:0] read_data_m_o,
   output logic        stall_m_o,
   output logic        err_m_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } size_e;

   // Counter wide enough to hold MAX_WAIT itself.
   localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
   // Value seen during the last permitted BUSY cycle without ready.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

   // ---------------------------------------------------------------- helpers
   // Reserved encodings (011, 110, 111) fall into the word case.
   function automatic size_e decode_size(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return SZ_B;
         2'b01:   return SZ_H;
         default: return SZ_W;
      endcase
   endfunction

   function automatic logic [3:0] store_be(input size_e sz, input logic [1:0] off);
      case (sz)
         SZ_B:    return 4'b0001 << off;
         SZ_H:    return 4'b0011 << {off[1], 1'b0};
         default: return 4'b1111;
      endcase
   endfunction

   // Replicating the data across lanes lets the byte enables alone pick the
   // destination, so no shifter is needed on the write path.
   function automatic logic [31:0] store_data(input size_e sz, input logic [31:0] wd);
      case (sz)
         SZ_B:    return {4{wd[7:0]}};
         SZ_H:    return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input size_e       sz,
                                                input logic        uns,
                                                input logic [1:0]  off,
                                                input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = rd[7:0];
         2'd1:    b = rd[15:8];
         2'd2:    b = rd[23:16];
         default: b = rd[31:24];
      endcase
      // Halfword lane comes from addr[1] only; addr[0] is never consulted.
      h = off[1] ? rd[31:16] : rd[15:0];
      case (sz)
         SZ_B:    return uns ? {24'd0, b} : {{24{b[7]}}, b};
         SZ_H:    return uns ? {16'd0, h} : {{16{h[15]}}, h};
         default: return rd;
      endcase
   endfunction

`ifdef MISALIGN_TRAP_EN
   function automatic logic misaligned(input size_e sz, input logic [1:0] off);
      case (sz)
         SZ_B:    return 1'b0;
         SZ_H:    return off[0];
         default: return off != 2'b00;
      endcase
   endfunction
`endif

   // ------------------------------------------------------------------ state
   state_e           state_q,     state_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic [31:0]      addr_q,      addr_d;
   size_e            size_q,      size_d;
   logic             uns_q,       uns_d;
   logic             we_q,        we_d;
   logic [3:0]       be_q,        be_d;
   logic [31:0]      wdata_q,     wdata_d;
   logic [31:0]      read_data_q, read_data_d;
   logic             err_q,       err_d;

   logic  req_in;
   size_e req_size;
   logic  trap;

   assign req_in   = mem_read_m_i | mem_write_m_i;
   assign req_size = decode_size(funct3_m_i);

`ifdef MISALIGN_TRAP_EN
   assign trap = misaligned(req_size, addr_m_i[1:0]);
`else
   assign trap = 1'b0;
`endif

   // ------------------------------------------------------- next-state logic
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned; a missing default here would infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      size_d      = size_q;
      uns_d       = uns_q;
      we_d        = we_q;
      be_d        = be_q;
      wdata_d     = wdata_q;
      read_data_d = read_data_q;
      err_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_in) begin
               // Capture the whole request so the memory sees stable values
               // for as long as BUSY lasts, regardless of the pipeline inputs.
               addr_d  = addr_m_i;
               size_d  = req_size;
               uns_d   = funct3_m_i[2];
               we_d    = mem_write_m_i;
               be_d    = mem_write_m_i ? store_be(req_size, addr_m_i[1:0]) : 4'b1111;
               wdata_d = mem_write_m_i ? store_data(req_size, wdata_m_i) : 32'd0;
               cnt_d   = '0;
               if (trap) begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
                  if (!mem_write_m_i) begin
                     read_data_d = 32'd0;
                  end
               end else begin
                  state_d = S_BUSY;
               end
            end
         end

         S_BUSY: begin
            if (dmem_ready_i) begin
               if (!we_q) begin
                  read_data_d = load_extend(size_q, uns_q, addr_q[1:0], dmem_rdata_i);
               end
               state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               // Last allowed wait cycle: give up and report the timeout.
               cnt_d   = cnt_q + 1'b1;
               state_d = S_DONE;
               err_d   = 1'b1;
               if (!we_q) begin
                  read_data_d = 32'd0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         // DONE ignores the request inputs: they still show the instruction
         // that was just served, and the pipeline advances at the end of DONE.
         S_DONE: state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------- registers
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of its _d input, independent of statement order.
      if (rst_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         addr_q      <= 32'd0;
         size_q      <= SZ_W;
         uns_q       <= 1'b0;
         we_q        <= 1'b0;
         be_q        <= 4'd0;
         wdata_q     <= 32'd0;
         read_data_q <= 32'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         we_q        <= we_d;
         be_q        <= be_d;
         wdata_q     <= wdata_d;
         read_data_q <= read_data_d;
         err_q       <= err_d;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign dmem_req_o    = (state_q == S_BUSY);
   assign dmem_we_o     = (state_q == S_BUSY) & we_q;
   assign dmem_addr_o   = {addr_q[31:2], 2'b00};
   assign dmem_be_o     = be_q;
   assign dmem_wdata_o  = wdata_q;
   assign read_data_m_o = read_data_q;
   assign err_m_o       = err_q;

   // The IDLE term is combinational so the instruction is frozen in the very
   // cycle it is first seen.
   assign stall_m_o = ((state_q == S_IDLE) & req_in) | (state_q == S_BUSY);

endmodule

// File: tb/tb_lsu_m.sv
// -----------------------------------------------------------------------------
// tb_lsu_m -- directed, table-driven bench for lsu_m (MAX_WAIT = 15).
// Zero-wait accesses come from a vector table; delayed ready, timeout,
// reset mid-request and misaligned access are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_lsu_m;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata, dmem_rdata;
   logic        dmem_ready;
   logic [31:0] read_data;
   logic        stall, err;

   always #5 clk = ~clk;

   lsu_m #(.MAX_WAIT(15)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .mem_read_m_i  (mem_read),
      .mem_write_m_i (mem_write),
      .funct3_m_i    (funct3),
      .addr_m_i      (addr),
      .wdata_m_i     (wdata),
      .dmem_req_o    (dmem_req),
      .dmem_we_o     (dmem_we),
      .dmem_addr_o   (dmem_addr),
      .dmem_be_o     (dmem_be),
      .dmem_wdata_o  (dmem_wdata),
      .dmem_rdata_i  (dmem_rdata),
      .dmem_ready_i  (dmem_ready),
      .read_data_m_o (read_data),
      .stall_m_o     (stall),
      .err_m_o       (err)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Observations from the most recent access() call.
   int          r_stalls, r_busy;
   logic        r_req, r_we, r_stable, r_err, r_req_done;
   logic [3:0]  r_be;
   logic [31:0] r_daddr, r_wdata, r_rdata;

   // Presents one instruction, answers the memory after `delay` wait cycles
   // (negative: never), and records what the DUT did up to the first
   // non-stalled cycle. Garbage is driven on rdata while not ready.
   task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdat, input int delay);
      logic done;
      @(posedge clk); #1;
      mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
      dmem_ready = 1'b0; dmem_rdata = ~rdat;
      r_stalls = 0; r_busy = 0; r_req = 1'b0; r_stable = 1'b1; done = 1'b0;
      r_we = 1'b0; r_be = 4'd0; r_daddr = 32'd0; r_wdata = 32'd0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         @(negedge clk);
         if (!stall) begin
            done = 1'b1;
         end else begin
            r_stalls++;
            if (dmem_req) begin
               if (!r_req) begin
                  r_req = 1'b1; r_we = dmem_we; r_be = dmem_be;
                  r_daddr = dmem_addr; r_wdata = dmem_wdata;
               end else if (dmem_we !== r_we || dmem_be !== r_be ||
                            dmem_addr !== r_daddr || dmem_wdata !== r_wdata) begin
                  r_stable = 1'b0;
               end
               r_busy++;
               if (delay >= 0 && r_busy > delay) begin
                  dmem_ready = 1'b1; dmem_rdata = rdat;
               end else begin
                  dmem_ready = 1'b0; dmem_rdata = ~rdat;
               end
            end else begin
               dmem_ready = 1'b0;
            end
         end
      end
      check("access_terminates", 32'(done), 32'd1);
      r_err = err; r_rdata = read_data; r_req_done = dmem_req;
      mem_read = 1'b0; mem_write = 1'b0; dmem_ready = 1'b0;
   endtask

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [3:0]  exp_be;
      logic [31:0] exp_daddr;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs [NV];

   initial begin
      logic [31:0] last_rd;

      //           rd    wr    f3      addr       wdata         rdata         be       daddr      wdata         rdata
      vecs[0]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF1234, 4'b1111, 32'h100, 32'h0,        32'hFFFFFF80}; // lb
      vecs[1]  = '{1'b0, 1'b1, 3'b001, 32'h022, 32'h0000BEEF, 32'h0,        4'b1100, 32'h020, 32'hBEEFBEEF, 32'h0};        // sh
      vecs[2]  = '{1'b0, 1'b1, 3'b000, 32'h011, 32'h123456A5, 32'h0,        4'b0010, 32'h010, 32'hA5A5A5A5, 32'h0};        // sb
      vecs[3]  = '{1'b0, 1'b1, 3'b010, 32'h048, 32'hDEADBEEF, 32'h0,        4'b1111, 32'h048, 32'hDEADBEEF, 32'h0};        // sw
      vecs[4]  = '{1'b1, 1'b0, 3'b100, 32'h201, 32'h0,        32'h1234F6AB, 4'b1111, 32'h200, 32'h0,        32'h000000F6}; // lbu
      vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h302, 32'h0,        32'h80017FFF, 4'b1111, 32'h300, 32'h0,        32'hFFFF8001}; // lh
      vecs[6]  = '{1'b1, 1'b0, 3'b101, 32'h302, 32'h0,        32'h80017FFF, 4'b1111, 32'h300, 32'h0,        32'h00008001}; // lhu
      vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h404, 32'h0,        32'hCAFEF00D, 4'b1111, 32'h404, 32'h0,        32'hCAFEF00D}; // lw
      vecs[8]  = '{1'b1, 1'b0, 3'b011, 32'h050, 32'h0,        32'h01020304, 4'b1111, 32'h050, 32'h0,        32'h01020304}; // rsvd load
      vecs[9]  = '{1'b0, 1'b1, 3'b110, 32'h054, 32'h11223344, 32'h0,        4'b1111, 32'h054, 32'h11223344, 32'h0};        // rsvd store
      vecs[10] = '{1'b1, 1'b1, 3'b000, 32'h063, 32'h0000007E, 32'hFFFFFFFF, 4'b1000, 32'h060, 32'h7E7E7E7E, 32'h0};        // rd+wr
      vecs[11] = '{1'b1, 1'b0, 3'b000, 32'h000, 32'h0,        32'h0000007F, 4'b1111, 32'h000, 32'h0,        32'h0000007F}; // lb +
      vecs[12] = '{1'b1, 1'b0, 3'b001, 32'h000, 32'h0,        32'h1234F00F, 4'b1111, 32'h000, 32'h0,        32'hFFFFF00F}; // lh lo
      vecs[13] = '{1'b0, 1'b1, 3'b000, 32'h000, 32'hFFFFFF5A, 32'h0,        4'b0001, 32'h000, 32'h5A5A5A5A, 32'h0};        // sb lane0

      // ---------------------------------------------------------- reset
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b0;
      addr = 32'd0; wdata = 32'd0; dmem_rdata = 32'd0; dmem_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_req",   32'(dmem_req),  32'd0);
      check("rst_we",    32'(dmem_we),   32'd0);
      check("rst_stall", 32'(stall),     32'd0);
      check("rst_err",   32'(err),       32'd0);
      check("rst_rdata", read_data,      32'd0);

      // ------------------------------------------------- zero-wait table
      last_rd = 32'd0;
      for (int i = 0; i < NV; i++) begin
         access(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr,
                vecs[i].wdata, vecs[i].rdata, 0);
         // Stores (including rd+wr) leave the load result untouched.
         if (!vecs[i].wr) last_rd = vecs[i].exp_rdata;
         check($sformatf("v%0d_req",    i), 32'(r_req),    32'd1);
         check($sformatf("v%0d_we",     i), 32'(r_we),     32'(vecs[i].wr));
         check($sformatf("v%0d_be",     i), 32'(r_be),     32'(vecs[i].exp_be));
         check($sformatf("v%0d_daddr",  i), r_daddr,       vecs[i].exp_daddr);
         if (vecs[i].wr) check($sformatf("v%0d_wdata", i), r_wdata, vecs[i].exp_wdata);
         check($sformatf("v%0d_stalls", i), 32'(r_stalls), 32'd2);
         check($sformatf("v%0d_rdata",  i), r_rdata,       last_rd);
         check($sformatf("v%0d_err",    i), 32'(r_err),    32'd0);
      end

      // --------------------------------------- non-memory instruction
      access(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 0);
      check("nop_stalls", 32'(r_stalls), 32'd0);
      check("nop_req",    32'(r_req),    32'd0);
      check("nop_rdata",  r_rdata,       last_rd);

      // -------------------------------- ready outside BUSY is ignored
      @(posedge clk); #1;
      dmem_ready = 1'b1; dmem_rdata = 32'h13579BDF;
      repeat (3) @(negedge clk);
      check("idle_ready_req",   32'(dmem_req), 32'd0);
      check("idle_ready_rdata", read_data,     last_rd);
      dmem_ready = 1'b0;

      // ------------------------------------- lhu with 3 wait cycles
      access(1'b1, 1'b0, 3'b101, 32'h40, 32'h0, 32'h00009ABC, 3);
      check("lhu_wait_stable", 32'(r_stable), 32'd1);
      check("lhu_wait_busy",   32'(r_busy),   32'd4);
      check("lhu_wait_stalls", 32'(r_stalls), 32'd5);
      check("lhu_wait_daddr",  r_daddr,       32'h40);
      check("lhu_wait_rdata",  r_rdata,       32'h00009ABC);

      // ----------------------------- reset in BUSY cycle 2 of a load
      @(posedge clk); #1;
      mem_read = 1'b1; funct3 = 3'b010; addr = 32'h90;
      @(posedge clk);            // -> BUSY cycle 1
      @(posedge clk);            // -> BUSY cycle 2
      @(negedge clk);
      check("rstmid_busy", 32'(dmem_req), 32'd1);
      rst = 1'b1; mem_read = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("rstmid_req",   32'(dmem_req), 32'd0);
      check("rstmid_stall", 32'(stall),    32'd0);
      check("rstmid_rdata", read_data,     32'd0);
      check("rstmid_err",   32'(err),      32'd0);
      repeat (3) @(negedge clk);
      check("rstmid_no_retry", 32'(dmem_req), 32'd0);

      // ------------------------------------------- timeout on lw
      access(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0BADF00D, 0);
      check("pre_to_rdata", r_rdata, 32'h0BADF00D);
      access(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 32'h12345678, -1);
      check("to_busy",     32'(r_busy),     32'd15);
      check("to_stalls",   32'(r_stalls),   32'd16);
      check("to_err",      32'(r_err),      32'd1);
      check("to_rdata",    r_rdata,         32'd0);
      check("to_req_drop", 32'(r_req_done), 32'd0);
      @(negedge clk);
      check("to_err_once", 32'(err),      32'd0);
      check("to_idle",     32'(stall),    32'd0);
      check("to_idle_req", 32'(dmem_req), 32'd0);

      // ----------------------------------------- misaligned access
      access(1'b1, 1'b0, 3'b010, 32'h4, 32'h0, 32'h0F0F0F0F, 0);
      check("pre_mis_rdata", r_rdata, 32'h0F0F0F0F);
      access(1'b1, 1'b0, 3'b010, 32'h2, 32'h0, 32'h55667788, 0);
`ifdef MISALIGN_TRAP_EN
      check("mis_lw_req",    32'(r_req),    32'd0);
      check("mis_lw_stalls", 32'(r_stalls), 32'd1);
      check("mis_lw_err",    32'(r_err),    32'd1);
      check("mis_lw_rdata",  r_rdata,       32'd0);
      access(1'b1, 1'b0, 3'b001, 32'h303, 32'h0, 32'h80017FFF, 0);
      check("mis_lh_req",    32'(r_req),    32'd0);
      check("mis_lh_err",    32'(r_err),    32'd1);
`else
      check("mis_lw_req",    32'(r_req),    32'd1);
      check("mis_lw_daddr",  r_daddr,       32'h0);
      check("mis_lw_stalls", 32'(r_stalls), 32'd2);
      check("mis_lw_err",    32'(r_err),    32'd0);
      check("mis_lw_rdata",  r_rdata,       32'h55667788);
      access(1'b1, 1'b0, 3'b001, 32'h303, 32'h0, 32'h80017FFF, 0);
      check("mis_lh_daddr",  r_daddr,       32'h300);
      check("mis_lh_rdata",  r_rdata,       32'hFFFF8001);
`endif

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
